dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-ported data memory between three requesters: load reads from the load/store unit,
//  store commits from the ROB, and address prefetch hints from the load/store unit. Fixed priority
//  store > load > prefetch, with a starvation guard for loads. Every completed read is also reported on a
//  fill port so the data cache can install the word. Sits between the LSM/ROB and the memory model.
// PARAMETERS
//  ADDR_W       32  address width, equals `Addr_Width
//  DATA_W       32  data width, equals `Data_Width
//  STORE_BURST  4   max consecutive store grants while a load waits; range 1..15
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  ld_req      in   1       load request; held high until ld_done
//  ld_addr     in   ADDR_W  load word address; already word-aligned; stable while ld_req
//  ld_done     out  1       one-cycle pulse, ld_data valid
//  ld_data     out  DATA_W  read word
//  st_valid    in   1       committed store offered
//  st_addr     in   ADDR_W  store word address
//  st_data     in   DATA_W  store data, lane-aligned
//  st_mask     in   4       byte enables
//  st_ready    out  1       store accepted this cycle (valid&&ready = transfer)
//  pf_valid    in   1       prefetch hint pulse
//  pf_addr     in   ADDR_W  prefetch address (low 2 bits ignored)
//  mem_req     out  1       memory request, held until mem_ack
//  mem_we      out  1       1 = write
//  mem_addr    out  ADDR_W  word address
//  mem_wdata   out  DATA_W  write data
//  mem_wmask   out  4       byte enables; 4'b0000 on reads
//  mem_ack     in   1       one-cycle completion pulse; mem_rdata valid on reads
//  mem_rdata   in   DATA_W  read data
//  fill_valid  out  1       one-cycle pulse for every completed read (load or prefetch)
//  fill_addr   out  ADDR_W  word address of fill
//  fill_data   out  DATA_W  fill word (= mem_rdata)
// BEHAVIOUR
//  - Reset: state IDLE; mem_req, mem_we, ld_done, st_ready, fill_valid = 0; mem_addr/wdata/wmask = 0;
//    prefetch buffer empty; starvation counter 0. Reset mid-operation abandons the access: mem_req low next
//    cycle, no ld_done/fill for it.
//  - FSM: IDLE -> WAIT on any grant; WAIT -> IDLE on mem_ack. No other states.
//  - IDLE grant (combinational pick, registered into mem_* at the clock edge):
//    store if st_valid and not (ld_req and cnt == STORE_BURST); else load if ld_req; else prefetch if buffer valid.
//  - st_ready is combinational: 1 only in IDLE when the store wins. The store is owned from that edge.
//  - Starvation counter: +1 on store grant while ld_req; cleared on load grant or when ld_req is low.
//  - WAIT: mem_* held constant; mem_ack in IDLE is ignored (stale).
//  - On mem_ack for a load: ld_done=1, ld_data=mem_rdata in the same cycle (combinational), and fill_valid=1.
//    If ld_req has dropped by the ack cycle (flush), ld_done is suppressed; fill_valid still fires.
//  - On mem_ack for a prefetch: fill_valid only. On mem_ack for a store: no pulse.
//  - Latency: grant edge -> mem_req high next cycle; min 2 cycles IDLE-to-IDLE with mem_ack in first WAIT cycle.
//  - Prefetch buffer: 1 entry {valid, word addr}. pf_valid overwrites (newest wins). Cleared on prefetch grant.
//    Dropped (not stored) if pf word addr == ld_addr while ld_req, or == the address in flight in WAIT.
//    If pf_valid arrives on the same edge the buffer is granted, the new hint is kept.
// STRUCTURE
//  - defines.v: add `Arb_Src_Width 2, `Arb_Src_None/Store/Load/Pref; reuse `Addr_Width, `Data_Width, `Addr_Mask.
//  - One sub-module dmem_arb_pick: pure combinational priority picker (inputs st_valid, ld_req, pf_buf_valid,
//    starve flag; output source encoding). FSM, counter, prefetch buffer stay in the top.
//  - Registered copy of the granted source held during WAIT to route mem_ack.
// TESTING
//  - Lone load 0x100, mem_ack 3 cycles after mem_req -> mem_we=0, mem_wmask=0, ld_done & fill_valid same cycle, ld_data=mem_rdata.
//  - st_valid (0x200, 0xDEADBEEF, 4'b0011) and ld_req 0x104 same cycle -> store first (st_ready=1), load next.
//  - st_valid held high 10 ops with ld_req high, STORE_BURST=4 -> grants S,S,S,S,L,S...; load within 5th op.
//  - pf_valid 0x300 while idle -> read 0x300, fill_valid=1, no ld_done; pf 0x104 while ld_req 0x104 -> no extra mem_req.
//  - ld_req drops during WAIT -> mem_ack produces fill_valid only, ld_done stays 0; next op proceeds.
//  - rst in WAIT -> mem_req 0 next cycle; late mem_ack ignored; no ld_done, fill_valid, or st_ready.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter: requester
// source encoding and default bus widths.
package dmem_port_arbiter_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int ARB_SRC_WIDTH = 2;

  typedef enum logic [ARB_SRC_WIDTH-1:0] {
    SRC_NONE  = 2'd0,
    SRC_STORE = 2'd1,
    SRC_LOAD  = 2'd2,
    SRC_PREF  = 2'd3
  } arb_src_e;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of requester, memory and fill signals around the data-memory arbiter.
// The master modport is the environment (LSU/ROB/memory); slave is the arbiter.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Store: st_valid && st_ready in one cycle is a transfer. Load: ld_req is
  // held until the ld_done pulse. Memory: mem_req is held until the mem_ack pulse.
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_done;
  logic [DATA_W-1:0] ld_data;
  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [3:0]        st_mask;
  logic              st_ready;
  logic              pf_valid;
  logic [ADDR_W-1:0] pf_addr;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;

  modport slave (
    input  ld_req, ld_addr, st_valid, st_addr, st_data, st_mask,
           pf_valid, pf_addr, mem_ack, mem_rdata,
    output ld_done, ld_data, st_ready, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wmask, fill_valid, fill_addr, fill_data
  );

  modport master (
    output ld_req, ld_addr, st_valid, st_addr, st_data, st_mask,
           pf_valid, pf_addr, mem_ack, mem_rdata,
    input  ld_done, ld_data, st_ready, mem_req, mem_we, mem_addr,
           mem_wdata, mem_wmask, fill_valid, fill_addr, fill_data
  );

endinterface

// File: rtl/dmem_port_arbiter_pick.sv
// Combinational fixed-priority source picker: store > load > prefetch, with the
// store losing to a waiting load once the starvation limit is reached.
module dmem_arb_pick
  import dmem_port_arbiter_pkg::*;
(
  input  logic     st_valid_i,
  input  logic     ld_req_i,
  input  logic     pf_buf_valid_i,
  input  logic     starve_i,
  output arb_src_e src_o
);

  always_comb begin
    src_o = SRC_NONE;
    if (st_valid_i && !starve_i) begin
      src_o = SRC_STORE;
    end else if (ld_req_i) begin
      src_o = SRC_LOAD;
    end else if (pf_buf_valid_i) begin
      src_o = SRC_PREF;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between store commits, loads and
// prefetch hints; every completed read is also reported on the fill port.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_WIDTH,
  parameter int DATA_W      = DATA_WIDTH,
  parameter int STORE_BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  dmem_port_arbiter_if.slave  bus,
  output logic [0:0]          dbg_state_o,
  output arb_src_e            dbg_src_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_WAIT   = 1'b1;
  localparam logic [3:0] BURST_MAX = 4'(STORE_BURST);

  logic [0:0]        state_q, state_d;
  arb_src_e          src_q, src_d, pick;
  logic [3:0]        cnt_q, cnt_d;
  logic              pf_vld_q, pf_vld_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;

  logic              idle, starve, grant, ack_hit, pf_drop;
  logic [ADDR_W-1:0] pf_word;

  assign idle    = (state_q == ST_IDLE);
  assign starve  = bus.ld_req && (cnt_q == BURST_MAX);
  assign grant   = idle && (pick != SRC_NONE);
  assign ack_hit = !idle && bus.mem_ack;
  assign pf_word = bus.pf_addr & ~ADDR_W'(3);
  // A hint is useless if the same word is already being loaded or is in flight.
  assign pf_drop = (bus.ld_req && (pf_word == bus.ld_addr)) ||
                   (!idle && (pf_word == mem_addr_q));

  dmem_arb_pick u_pick (
    .st_valid_i     (bus.st_valid),
    .ld_req_i       (bus.ld_req),
    .pf_buf_valid_i (pf_vld_q),
    .starve_i       (starve),
    .src_o          (pick)
  );

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if (grant) begin
      state_d   = ST_WAIT;
      src_d     = pick;
      mem_req_d = 1'b1;
      unique case (pick)
        SRC_STORE: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = bus.st_addr;
          mem_wdata_d = bus.st_data;
          mem_wmask_d = bus.st_mask;
        end
        SRC_LOAD: begin
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.ld_addr;
          mem_wdata_d = '0;
          mem_wmask_d = 4'b0000;
        end
        default: begin
          mem_we_d    = 1'b0;
          mem_addr_d  = pf_addr_q;
          mem_wdata_d = '0;
          mem_wmask_d = 4'b0000;
        end
      endcase
    end else if (ack_hit) begin
      state_d   = ST_IDLE;
      src_d     = SRC_NONE;
      mem_req_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.ld_req || (grant && pick == SRC_LOAD)) begin
      cnt_d = 4'd0;
    end else if (grant && pick == SRC_STORE) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // A fresh hint wins over clearing the entry it replaces on a grant edge.
  always_comb begin
    pf_vld_d  = pf_vld_q;
    pf_addr_d = pf_addr_q;
    if (bus.pf_valid && !pf_drop) begin
      pf_vld_d  = 1'b1;
      pf_addr_d = pf_word;
    end else if (grant && pick == SRC_PREF) begin
      pf_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      src_q       <= SRC_NONE;
      cnt_q       <= 4'd0;
      pf_vld_q    <= 1'b0;
      pf_addr_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= 4'b0000;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      pf_vld_q    <= pf_vld_d;
      pf_addr_q   <= pf_addr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wmask  = mem_wmask_q;
  assign bus.st_ready   = !rst && idle && (pick == SRC_STORE);
  // A load flushed before its ack still installs the word, but is not reported done.
  assign bus.ld_done    = !rst && ack_hit && (src_q == SRC_LOAD) && bus.ld_req;
  assign bus.ld_data    = bus.mem_rdata;
  assign bus.fill_valid = !rst && ack_hit && ((src_q == SRC_LOAD) || (src_q == SRC_PREF));
  assign bus.fill_addr  = mem_addr_q;
  assign bus.fill_data  = bus.mem_rdata;

  assign dbg_state_o = state_q;
  assign dbg_src_o   = src_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized checks of dmem_port_arbiter against a word-array
// memory model and the priority / starvation / prefetch rules.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int STORE_BURST = 4;

  logic       clk;
  logic       rst;
  logic [0:0] dbg_state;
  arb_src_e   dbg_src;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STORE_BURST(STORE_BURST)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state),
    .dbg_src_o   (dbg_src)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  logic [32:0] txn_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          ack_dly  = 0;
  int          wait_cnt = 0;
  bit          mem_en   = 1'b1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: edge, then memory responder, then settle.
  task automatic step();
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    if (mem_en && bus.mem_req === 1'b1) begin
      if (wait_cnt >= ack_dly) begin
        bus.mem_ack = 1'b1;
        if (bus.mem_we) begin
          mem_arr[bus.mem_addr] = merge(mem_rd(bus.mem_addr), bus.mem_wdata, bus.mem_wmask);
          bus.mem_rdata = $urandom;
        end else begin
          bus.mem_rdata = mem_rd(bus.mem_addr);
        end
        txn_q.push_back({bus.mem_we, bus.mem_addr});
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    #1;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      ok = (bus.mem_req === 1'b0);
    end
    chk({tag, "_idle"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_ld(input logic [31:0] a, input string tag, output int n);
    bit          got;
    logic [31:0] e;
    got = 1'b0;
    n   = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      n++;
      if (bus.ld_done === 1'b1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        chk({tag, "_ld_data"}, 64'(bus.ld_data), 64'(e));
        chk({tag, "_fill_v"}, 64'(bus.fill_valid), 64'd1);
        chk({tag, "_fill_a"}, 64'(bus.fill_addr), 64'(a));
        chk({tag, "_fill_d"}, 64'(bus.fill_data), 64'(e));
        bus.ld_req = 1'b0;
      end
    end
    chk({tag, "_ld_seen"}, 64'(got), 64'd1);
    if (!got) begin
      bus.ld_req = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    step();
  endtask

  task automatic do_load(input logic [31:0] a, input string tag);
    int n;
    exp_q.push_back(ref_rd(a));
    bus.ld_req  = 1'b1;
    bus.ld_addr = a;
    wait_ld(a, tag, n);
  endtask

  task automatic wait_fill(input logic [31:0] a, input string tag);
    bit          got;
    logic [31:0] e;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (bus.fill_valid === 1'b1) begin
        got = 1'b1;
        e = exp_q.pop_front();
        chk({tag, "_fill_a"}, 64'(bus.fill_addr), 64'(a));
        chk({tag, "_fill_d"}, 64'(bus.fill_data), 64'(e));
        chk({tag, "_no_lddone"}, 64'(bus.ld_done), 64'd0);
      end
    end
    chk({tag, "_fill_seen"}, 64'(got), 64'd1);
    if (!got && exp_q.size() > 0) void'(exp_q.pop_front());
    step();
  endtask

  task automatic do_pref(input logic [31:0] a_raw, input string tag);
    logic [31:0] w;
    w = a_raw & ~32'd3;
    exp_q.push_back(ref_rd(w));
    bus.pf_valid = 1'b1;
    bus.pf_addr  = a_raw;
    step();
    bus.pf_valid = 1'b0;
    wait_fill(w, tag);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input string tag);
    bit acc;
    acc = 1'b0;
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_mask  = m;
    for (int i = 0; i < 40 && !acc; i++) begin
      #1;
      acc = bus.st_ready;
      step();
    end
    bus.st_valid = 1'b0;
    chk({tag, "_acc"}, 64'(acc), 64'd1);
    if (acc) begin
      ref_mem[a] = merge(ref_rd(a), d, m);
      chk({tag, "_we"}, 64'(bus.mem_we), 64'd1);
      chk({tag, "_addr"}, 64'(bus.mem_addr), 64'(a));
      chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(d));
      chk({tag, "_wmask"}, 64'(bus.mem_wmask), 64'(m));
    end
    wait_idle(tag);
  endtask

  initial begin
    int          n;
    int          n_st;
    bit          acc;
    bit          ld_seen;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic [32:0] t;

    bus.ld_req = 1'b0; bus.ld_addr = '0;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_mask = '0;
    bus.pf_valid = 1'b0; bus.pf_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    // reset: outputs quiet even with a store offered
    rst = 1'b1;
    repeat (3) step();
    bus.st_valid = 1'b1;
    #1;
    chk("rst_st_ready", 64'(bus.st_ready), 64'd0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst_mem_wmask", 64'(bus.mem_wmask), 64'd0);
    chk("rst_ld_done", 64'(bus.ld_done), 64'd0);
    chk("rst_fill", 64'(bus.fill_valid), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    chk("rst_src", 64'(dbg_src), 64'(SRC_NONE));
    bus.st_valid = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_pf_empty", 64'(bus.mem_req), 64'd0);

    // lone load, ack three cycles after mem_req
    ack_dly = 3;
    txn_q.delete();
    exp_q.push_back(ref_rd(32'h100));
    bus.ld_req = 1'b1; bus.ld_addr = 32'h100;
    step();
    chk("t1_req_lat", 64'(bus.mem_req), 64'd1);
    chk("t1_we", 64'(bus.mem_we), 64'd0);
    chk("t1_wmask", 64'(bus.mem_wmask), 64'd0);
    chk("t1_addr", 64'(bus.mem_addr), 64'h100);
    wait_ld(32'h100, "t1", n);
    chk("t1_done_lat", 64'(n), 64'd3);

    // store and load together: store first, minimum back-to-back latency
    ack_dly = 0;
    txn_q.delete();
    exp_q.push_back(ref_rd(32'h104));
    bus.st_valid = 1'b1; bus.st_addr = 32'h200; bus.st_data = 32'hDEADBEEF; bus.st_mask = 4'b0011;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h104;
    #1;
    chk("t2_st_ready", 64'(bus.st_ready), 64'd1);
    step();
    bus.st_valid = 1'b0;
    ref_mem[32'h200] = merge(ref_rd(32'h200), 32'hDEADBEEF, 4'b0011);
    wait_ld(32'h104, "t2", n);
    chk("t2_ld_lat", 64'(n), 64'd2);
    chk("t2_n_txn", 64'(txn_q.size()), 64'd2);
    if (txn_q.size() == 2) begin
      chk("t2_first", 64'(txn_q[0]), {31'd0, 1'b1, 32'h200});
      chk("t2_second", 64'(txn_q[1]), {31'd0, 1'b0, 32'h104});
    end
    do_load(32'h200, "t2_rb");

    // store stream against a waiting load: burst limit then the load
    ack_dly = 1;
    txn_q.delete();
    exp_q.push_back(ref_rd(32'h108));
    bus.ld_req = 1'b1; bus.ld_addr = 32'h108;
    n_st = 0; ld_seen = 1'b0;
    bus.st_valid = 1'b1; bus.st_addr = 32'h400; bus.st_data = $urandom;
    bus.st_mask = 4'($urandom_range(1, 15));
    for (int i = 0; i < 300 && (n_st < 9 || !ld_seen); i++) begin
      #1;
      acc = bus.st_ready;
      a = bus.st_addr; d = bus.st_data; m = bus.st_mask;
      step();
      if (acc) begin
        ref_mem[a] = merge(ref_rd(a), d, m);
        n_st++;
        if (n_st < 9) begin
          bus.st_addr = 32'h400 + 32'(4 * n_st); bus.st_data = $urandom;
          bus.st_mask = 4'($urandom_range(1, 15));
        end else begin
          bus.st_valid = 1'b0;
        end
      end
      if (bus.ld_done === 1'b1) begin
        chk("t3_ld_data", 64'(bus.ld_data), 64'(exp_q.pop_front()));
        bus.ld_req = 1'b0;
        ld_seen = 1'b1;
      end
    end
    bus.st_valid = 1'b0;
    chk("t3_all_done", 64'(ld_seen && n_st == 9), 64'd1);
    if (!ld_seen) begin
      bus.ld_req = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    wait_idle("t3");
    chk("t3_n_txn", 64'(txn_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < txn_q.size(); i++) begin
      if (i == STORE_BURST) t = {1'b0, 32'h108};
      else t = {1'b1, 32'h400 + 32'(4 * (i < STORE_BURST ? i : i - 1))};
      chk($sformatf("t3_op%0d", i), 64'(txn_q[i]), 64'(t));
    end
    do_load(32'h408, "t3_rb");

    // prefetch while idle; hint kept when it lands on a grant edge
    ack_dly = 1;
    txn_q.delete();
    do_pref(32'h302, "t4_pf");
    exp_q.push_back(ref_rd(32'h310));
    exp_q.push_back(ref_rd(32'h314));
    bus.pf_valid = 1'b1; bus.pf_addr = 32'h310;
    step();
    bus.pf_addr = 32'h314;
    step();
    bus.pf_valid = 1'b0;
    wait_fill(32'h310, "t4_pfa");
    wait_fill(32'h314, "t4_pfb");

    // hint matching the pending load is discarded
    txn_q.delete();
    exp_q.push_back(ref_rd(32'h104));
    bus.ld_req = 1'b1; bus.ld_addr = 32'h104;
    bus.pf_valid = 1'b1; bus.pf_addr = 32'h104;
    step();
    bus.pf_valid = 1'b0;
    wait_ld(32'h104, "t4_ld", n);
    repeat (6) step();
    chk("t4_no_extra", 64'(txn_q.size()), 64'd1);

    // load flushed during WAIT: fill only, then normal traffic resumes
    ack_dly = 2;
    exp_q.push_back(ref_rd(32'h10C));
    bus.ld_req = 1'b1; bus.ld_addr = 32'h10C;
    step();
    chk("t5_req", 64'(bus.mem_req), 64'd1);
    bus.ld_req = 1'b0;
    wait_fill(32'h10C, "t5_flush");
    do_load(32'h110, "t5_next");

    // reset while waiting: access abandoned, late ack ignored
    mem_en = 1'b0;
    bus.ld_req = 1'b1; bus.ld_addr = 32'h100;
    step();
    chk("t6_req", 64'(bus.mem_req), 64'd1);
    step();
    rst = 1'b1;
    bus.ld_req = 1'b0;
    bus.st_valid = 1'b1; bus.st_addr = 32'h500;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
    #1;
    chk("t6_rst_lddone", 64'(bus.ld_done), 64'd0);
    chk("t6_rst_fill", 64'(bus.fill_valid), 64'd0);
    chk("t6_rst_stready", 64'(bus.st_ready), 64'd0);
    step();
    chk("t6_req_low", 64'(bus.mem_req), 64'd0);
    chk("t6_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    bus.st_valid = 1'b0;
    bus.mem_ack = 1'b1;
    #1;
    chk("t6_late_lddone", 64'(bus.ld_done), 64'd0);
    chk("t6_late_fill", 64'(bus.fill_valid), 64'd0);
    step();
    chk("t6_late_req", 64'(bus.mem_req), 64'd0);
    chk("t6_late_state", 64'(dbg_state), 64'd0);
    mem_en = 1'b1;
    do_load(32'h100, "t6_after");

    // randomized serial traffic against the memory model
    for (int k = 0; k < 40; k++) begin
      ack_dly = $urandom_range(0, 3);
      a = 32'h800 + 32'(4 * $urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       do_store(a, $urandom, 4'($urandom_range(1, 15)), $sformatf("rnd%0d_st", k));
        1:       do_load(a, $sformatf("rnd%0d_ld", k));
        default: do_pref(a | 32'($urandom_range(0, 3)), $sformatf("rnd%0d_pf", k));
      endcase
    end

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
